// File: rtl/calc_entry_ctrl_pkg.sv
// Shared key codes, FSM state type and sizing for the BCD calculator entry sequencer.
package calc_entry_ctrl_pkg;

  localparam int DIGITS_DEF = 4;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;
  localparam logic [3:0] KEY_CLR   = 4'hD;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return ((k == KEY_PLUS) || (k == KEY_MINUS));
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Keypad, ALU and display signal bundle; slave is the sequencer's view, master the environment's.
interface calc_entry_ctrl_if #(parameter int W = 16);

  logic         key_valid;
  logic [3:0]   key_code;
  logic         key_ready;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_op;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         alu_valid;
  logic [W-1:0] disp_bcd;
  logic         disp_err;
  logic         busy;

  modport slave (
    input  key_valid, key_code, alu_result, alu_carry, alu_valid,
    output key_ready, alu_a, alu_b, alu_op, disp_bcd, disp_err, busy
  );

  modport master (
    output key_valid, key_code, alu_result, alu_carry, alu_valid,
    input  key_ready, alu_a, alu_b, alu_op, disp_bcd, disp_err, busy
  );

endinterface

// File: rtl/calc_entry_ctrl_bcd_digit_shifter.sv
// One BCD operand register with its digit counter; enforces the no-leading-zero and full rules.
module bcd_digit_shifter #(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_val_i,
  input  logic          load_first_i,
  input  logic          shift_i,
  input  logic [3:0]    digit_i,
  input  logic [W-1:0]  val_i,
  output logic [W-1:0]  val_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-value selection; clear beats a result load, which beats digit entry.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      val_d = '0;
      cnt_d = '0;
    end else if (load_val_i) begin
      val_d = val_i;
      cnt_d = CW'(DIGITS);
    end else if (load_first_i) begin
      if (digit_i == 4'd0) begin
        val_d = '0;
        cnt_d = '0;
      end else begin
        val_d = {{(W-4){1'b0}}, digit_i};
        cnt_d = CW'(1);
      end
    end else if (shift_i) begin
      if (((cnt_q == '0) && (digit_i == 4'd0)) || (cnt_q == CW'(DIGITS))) begin
        val_d = val_q;
        cnt_d = cnt_q;
      end else begin
        val_d = {val_q[W-5:0], digit_i};
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      val_d = val_q;
      cnt_d = cnt_q;
    end
  end

  // Operand and digit-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o = val_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad sequencer: builds operands A/B, drives the combinational BCD ALU for one EXEC cycle,
// captures its result and selects what the display shows.
module calc_entry_ctrl
  import calc_entry_ctrl_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  calc_entry_ctrl_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   pend_q, pend_d;
  logic   pend_op_q, pend_op_d;

  logic          a_clr_s, a_load_s, a_first_s, a_shift_s;
  logic          b_clr_s, b_shift_s;
  logic [W-1:0]  a_val_s, b_val_s;
  logic [CW-1:0] a_cnt_s, b_cnt_s;
  logic          key_s, err_s;
  logic [3:0]    code_s;
  logic [W-1:0]  disp_s;

  assign code_s = bus.key_code;
  assign key_s  = bus.key_valid && (state_q != ST_EXEC);
  assign err_s  = bus.alu_carry | ~bus.alu_valid;

  // Next-state and operand-control decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pend_d    = pend_q;
    pend_op_d = pend_op_q;
    a_clr_s   = 1'b0;
    a_load_s  = 1'b0;
    a_first_s = 1'b0;
    a_shift_s = 1'b0;
    b_clr_s   = 1'b0;
    b_shift_s = 1'b0;
    if (state_q == ST_EXEC) begin
      // The ALU has had the whole cycle to settle; capture happens on this edge.
      if (err_s) begin
        state_d = ST_ERR;
      end else if (pend_q) begin
        a_load_s = 1'b1;
        b_clr_s  = 1'b1;
        op_d     = pend_op_q;
        pend_d   = 1'b0;
        state_d  = ST_ENTER_B;
      end else begin
        a_load_s = 1'b1;
        state_d  = ST_SHOW;
      end
    end else if (key_s && (code_s == KEY_CLR)) begin
      a_clr_s   = 1'b1;
      b_clr_s   = 1'b1;
      op_d      = 1'b0;
      pend_d    = 1'b0;
      pend_op_d = 1'b0;
      state_d   = ST_ENTER_A;
    end else if (key_s) begin
      case (state_q)
        ST_ENTER_A: begin
          if (is_digit(code_s)) begin
            a_shift_s = 1'b1;
          end else if (is_op(code_s)) begin
            op_d    = (code_s == KEY_MINUS);
            b_clr_s = 1'b1;
            state_d = ST_ENTER_B;
          end else begin
            state_d = ST_ENTER_A;
          end
        end
        ST_ENTER_B: begin
          if (is_digit(code_s)) begin
            b_shift_s = 1'b1;
          end else if (is_op(code_s) && (b_cnt_s == '0)) begin
            op_d = (code_s == KEY_MINUS);
          end else if (is_op(code_s)) begin
            pend_d    = 1'b1;
            pend_op_d = (code_s == KEY_MINUS);
            state_d   = ST_EXEC;
          end else if (code_s == KEY_EQ) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_ENTER_B;
          end
        end
        ST_SHOW: begin
          if (is_digit(code_s)) begin
            a_first_s = 1'b1;
            state_d   = ST_ENTER_A;
          end else if (is_op(code_s)) begin
            op_d    = (code_s == KEY_MINUS);
            b_clr_s = 1'b1;
            state_d = ST_ENTER_B;
          end else if (code_s == KEY_EQ) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state and operation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ENTER_A;
      op_q      <= 1'b0;
      pend_q    <= 1'b0;
      pend_op_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pend_q    <= pend_d;
      pend_op_q <= pend_op_d;
    end
  end

  bcd_digit_shifter #(.DIGITS(DIGITS)) u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (a_clr_s),
    .load_val_i   (a_load_s),
    .load_first_i (a_first_s),
    .shift_i      (a_shift_s),
    .digit_i      (code_s),
    .val_i        (bus.alu_result),
    .val_o        (a_val_s),
    .cnt_o        (a_cnt_s)
  );

  bcd_digit_shifter #(.DIGITS(DIGITS)) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (b_clr_s),
    .load_val_i   (1'b0),
    .load_first_i (1'b0),
    .shift_i      (b_shift_s),
    .digit_i      (code_s),
    .val_i        ('0),
    .val_o        (b_val_s),
    .cnt_o        (b_cnt_s)
  );

  // Display source; an empty A is always zero, so it shows as zero explicitly.
  always_comb begin
    disp_s = '0;
    case (state_q)
      ST_ENTER_A: disp_s = (a_cnt_s == '0) ? '0 : a_val_s;
      ST_ENTER_B: disp_s = (b_cnt_s != '0) ? b_val_s : a_val_s;
      ST_SHOW:    disp_s = a_val_s;
      ST_EXEC:    disp_s = a_val_s;
      ST_ERR:     disp_s = '0;
      default:    disp_s = '0;
    endcase
  end

  assign bus.alu_a     = a_val_s;
  assign bus.alu_b     = b_val_s;
  assign bus.alu_op    = op_q;
  assign bus.disp_bcd  = disp_s;
  assign bus.disp_err  = (state_q == ST_ERR);
  assign bus.busy      = (state_q == ST_EXEC);
  assign bus.key_ready = (state_q != ST_EXEC);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: behavioural BCD ALU downstream, decimal reference model of the keypad rules.
module tb_calc_entry_ctrl;
  import calc_entry_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  calc_entry_ctrl_if #(.W(16)) bus ();

  calc_entry_ctrl #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  // Downstream ALU: negative -> invalid only, overflow -> carry and invalid.
  int alu_sum;
  always_comb begin
    alu_sum = bus.alu_op ? (from_bcd(bus.alu_a) - from_bcd(bus.alu_b))
                         : (from_bcd(bus.alu_a) + from_bcd(bus.alu_b));
    bus.alu_carry  = (alu_sum > 9999);
    bus.alu_valid  = (alu_sum >= 0) && (alu_sum <= 9999);
    bus.alu_result = to_bcd((alu_sum < 0) ? (alu_sum + 10000) : (alu_sum % 10000));
  end

  localparam int M_A = 0, M_B = 1, M_X = 2, M_SHOW = 3, M_ERR = 4;
  int m_st, m_a, m_ac, m_b, m_bc, m_op, m_pend, m_pop;
  logic       drop_en;
  logic [3:0] drop_code;

  task automatic model_reset();
    m_st = M_A; m_a = 0; m_ac = 0; m_b = 0; m_bc = 0; m_op = 0; m_pend = 0; m_pop = 0;
  endtask

  task automatic put_digit(inout int v, inout int c, input int d);
    if (!((c == 0) && (d == 0)) && (c < 4)) begin
      v = v * 10 + d;
      c = c + 1;
    end
  endtask

  task automatic model_key(input int k);
    if (m_st == M_X || k > 13) return;
    if (k == 13) begin
      model_reset();
      return;
    end
    case (m_st)
      M_A: begin
        if (k <= 9) put_digit(m_a, m_ac, k);
        else if (k <= 11) begin m_op = (k == 11); m_b = 0; m_bc = 0; m_st = M_B; end
      end
      M_B: begin
        if (k <= 9) put_digit(m_b, m_bc, k);
        else if (k <= 11 && m_bc == 0) m_op = (k == 11);
        else if (k <= 11) begin m_pend = 1; m_pop = (k == 11); m_st = M_X; end
        else m_st = M_X;
      end
      M_SHOW: begin
        if (k <= 9) begin m_a = 0; m_ac = 0; put_digit(m_a, m_ac, k); m_st = M_A; end
        else if (k <= 11) begin m_op = (k == 11); m_b = 0; m_bc = 0; m_st = M_B; end
        else m_st = M_X;
      end
      default: ;
    endcase
  endtask

  task automatic model_exec();
    int r;
    r = m_op ? (m_a - m_b) : (m_a + m_b);
    if (r < 0 || r > 9999) begin
      m_st = M_ERR;
    end else begin
      m_a = r;
      if (m_pend != 0) begin
        m_ac = 4; m_op = m_pop; m_b = 0; m_bc = 0; m_pend = 0; m_st = M_B;
      end else begin
        m_st = M_SHOW;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int d;
    d = (m_st == M_ERR) ? 0 : ((m_st == M_B && m_bc > 0) ? m_b : m_a);
    chk("busy", 32'(bus.busy), 32'(m_st == M_X));
    chk("key_ready", 32'(bus.key_ready), 32'(m_st != M_X));
    chk("disp_err", 32'(bus.disp_err), 32'(m_st == M_ERR));
    if (m_st != M_X) chk("disp_bcd", 32'(bus.disp_bcd), 32'(to_bcd(d)));
    if (m_st != M_ERR) begin
      chk("alu_a", 32'(bus.alu_a), 32'(to_bcd(m_a)));
      chk("alu_b", 32'(bus.alu_b), 32'(to_bcd(m_b)));
      chk("alu_op", 32'(bus.alu_op), 32'(m_op));
    end
  endtask

  // Called just after a falling edge: key held across one rising edge, then checked.
  task automatic step(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    model_key(int'(code));
    @(negedge clk);
    bus.key_valid = 1'b0;
    check_outputs();
    if (m_st == M_X) begin
      if (drop_en) begin
        bus.key_valid = 1'b1;
        bus.key_code  = drop_code;
      end
      @(negedge clk);
      bus.key_valid = 1'b0;
      model_exec();
      check_outputs();
    end
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    drop_en   = 1'b0;
    drop_code = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // 1: 12 + 34 =
    step(4'd1); step(4'd2); step(KEY_PLUS); step(4'd3); step(4'd4); step(KEY_EQ);
    chk("t1_disp", 32'(bus.disp_bcd), 32'h0046);
    chk("t1_err", 32'(bus.disp_err), 32'h0);

    // 2: fifth digit ignored; leading zeros ignored
    step(KEY_CLR);
    step(4'd1); step(4'd2); step(4'd3); step(4'd4); step(4'd5);
    chk("t2_full", 32'(bus.alu_a), 32'h1234);
    step(KEY_CLR); step(4'd0); step(4'd0);
    chk("t2_zero", 32'(bus.alu_a), 32'h0);
    step(4'd1);
    chk("t2_first", 32'(bus.alu_a), 32'h0001);

    // 3: overflow -> ERR, keys ignored until clear
    step(KEY_CLR);
    step(4'd9); step(4'd9); step(4'd9); step(4'd9); step(KEY_PLUS); step(4'd1); step(KEY_EQ);
    chk("t3_err", 32'(bus.disp_err), 32'h1);
    chk("t3_disp", 32'(bus.disp_bcd), 32'h0);
    step(4'd5);
    chk("t3_hold", 32'(bus.disp_err), 32'h1);
    step(KEY_CLR);
    chk("t3_clr_err", 32'(bus.disp_err), 32'h0);
    chk("t3_clr_disp", 32'(bus.disp_bcd), 32'h0);

    // 4: chain 5+3-2=, then repeat with a key dropped during EXEC
    step(4'd5); step(KEY_PLUS); step(4'd3); step(KEY_MINUS);
    chk("t4_chain", 32'(bus.alu_a), 32'h0008);
    step(4'd2); step(KEY_EQ);
    chk("t4_show", 32'(bus.disp_bcd), 32'h0006);
    drop_en = 1'b1; drop_code = 4'd7;
    step(KEY_EQ);
    drop_en = 1'b0;
    chk("t4_repeat", 32'(bus.disp_bcd), 32'h0004);

    // 5: 3-7 negative -> ERR, clear presented in EXEC is dropped
    step(KEY_CLR);
    step(4'd3); step(KEY_MINUS); step(4'd7);
    drop_en = 1'b1; drop_code = KEY_CLR;
    step(KEY_EQ);
    drop_en = 1'b0;
    chk("t5_err", 32'(bus.disp_err), 32'h1);

    // 6: reset asserted between '=' and the EXEC edge
    step(KEY_CLR);
    step(4'd1); step(KEY_PLUS); step(4'd2);
    bus.key_valid = 1'b1;
    bus.key_code  = KEY_EQ;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    step(4'd7);
    chk("t6_enter_a", 32'(bus.alu_a), 32'h0007);

    // Random key sequences against the model
    step(KEY_CLR);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      step(4'($urandom_range(0, 9)));
      else if (r < 75) step(($urandom_range(0, 1) != 0) ? KEY_MINUS : KEY_PLUS);
      else if (r < 88) step(KEY_EQ);
      else if (r < 93) step(KEY_CLR);
      else             step(4'($urandom_range(14, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
